// File: rtl/line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// line_buf_ctrl
//
// Turns a raster-order pixel stream into vertical pixel columns LINES tall,
// for feeding a sliding-window filter. LINES-1 previous rows are kept in
// circular row memories addressed by the column counter. Each accepted
// pixel shifts its column down by one row, so no FIFO pointers are needed.
//
// Ports
//   sclk      : clock, all logic on the rising edge
//   rst_n     : synchronous active-low reset
//   in_flag   : in_data valid this cycle (single-cycle strobe, any gaps)
//   in_data   : incoming pixel, raster order
//   clr       : synchronous frame restart (wins over in_flag)
//   out_flag  : out_col / out_x / out_y valid this cycle
//   out_col   : column, MSB slice = oldest row, LSB slice = newest pixel
//   out_x     : column index of out_col
//   out_y     : row index of the newest pixel in out_col
//   frame_end : pulses with out_flag for the last pixel of the frame
// ---------------------------------------------------------------------------
module line_buf_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 50,
  parameter int IMG_H = 50,
  parameter int LINES = 3
) (
  input  logic                       sclk,
  input  logic                       rst_n,
  input  logic                       in_flag,
  input  logic [DW-1:0]              in_data,
  input  logic                       clr,
  output logic                       out_flag,
  output logic [LINES*DW-1:0]        out_col,
  output logic [$clog2(IMG_W)-1:0]   out_x,
  output logic [$clog2(IMG_H)-1:0]   out_y,
  output logic                       frame_end
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  // First row whose pixels complete a full column.
  localparam logic [YW-1:0] Y_PRIMED = YW'(LINES - 1);

  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic               accept;
  logic [LINES*DW-1:0] col;

  // Row memory 0 holds the previous row, row memory LINES-2 the oldest one.
  logic [DW-1:0] mem [LINES-1][IMG_W];

  // A pixel is taken only outside reset and when no restart is requested.
  assign accept = rst_n & ~clr & in_flag;

  // Assemble the column from pre-write memory contents plus the new pixel.
  always_comb begin
    // NOTE: a full default assignment before the loop keeps every bit of col
    // driven on every path, so no latch can be inferred.
    col           = '0;
    col[DW-1:0]   = in_data;
    for (int k = 0; k < LINES - 1; k++) begin
      col[(k+1)*DW +: DW] = mem[k][x];
    end
  end

  // NOTE: the row memories have no reset; stale contents are overwritten while
  // the first LINES-1 rows of a frame prime the buffer, and out_flag stays low
  // until then. Leaving reset off also keeps them mappable to block RAM.
  always_ff @(posedge sclk) begin
    if (accept) begin
      mem[0][x] <= in_data;
      // Non-blocking reads below see the contents from before this edge,
      // which is exactly the downward shift of the column.
      for (int k = 1; k < LINES - 1; k++) begin
        mem[k][x] <= mem[k-1][x];
      end
    end
  end

  // Raster position counters.
  always_ff @(posedge sclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (in_flag) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Output registers: one cycle after acceptance; column data held in gaps.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      out_flag  <= 1'b0;
      frame_end <= 1'b0;
      out_col   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (clr) begin
      out_flag  <= 1'b0;
      frame_end <= 1'b0;
    end else if (in_flag) begin
      out_flag  <= (y >= Y_PRIMED);
      frame_end <= (x == X_LAST) && (y == Y_LAST);
      out_col   <= col;
      out_x     <= x;
      out_y     <= y;
    end else begin
      out_flag  <= 1'b0;
      frame_end <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buf_ctrl
//
// Directed bench for line_buf_ctrl with a 4x4 image and 3-row columns.
// Pixel value = base + 16*row + col. For a pixel at row r >= 2 the column
// must be {pix(r-2,c), pix(r-1,c), pix(r,c)}; first/last columns of each
// frame are also compared against hand-written constants.
// ---------------------------------------------------------------------------
module tb_line_buf_ctrl;

  localparam int DW    = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int LINES = 3;

  logic                  sclk;
  logic                  rst_n;
  logic                  in_flag;
  logic [DW-1:0]         in_data;
  logic                  clr;
  logic                  out_flag;
  logic [LINES*DW-1:0]   out_col;
  logic [1:0]            out_x;
  logic [1:0]            out_y;
  logic                  frame_end;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Last expected column, valid only after an output-producing pixel.
  logic                held_valid = 1'b0;
  logic [LINES*DW-1:0] held_col   = '0;
  logic [1:0]          held_x     = '0;
  logic [1:0]          held_y     = '0;

  line_buf_ctrl #(
    .DW   (DW),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .LINES(LINES)
  ) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .in_flag  (in_flag),
    .in_data  (in_data),
    .clr      (clr),
    .out_flag (out_flag),
    .out_col  (out_col),
    .out_x    (out_x),
    .out_y    (out_y),
    .frame_end(frame_end)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle cycles: no output pulse, outputs held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk); #1;
      check("idle_flag", 32'(out_flag), 32'd0);
      check("idle_fend", 32'(frame_end), 32'd0);
      if (held_valid) begin
        check("hold_col", 32'(out_col), 32'(held_col));
        check("hold_x",   32'(out_x),   32'(held_x));
        check("hold_y",   32'(out_y),   32'(held_y));
      end
    end
  endtask

  // Drive one pixel at (r,c) and check the registered result.
  task automatic pixel(input logic [7:0] base, input int r, input int c);
    logic [7:0] p0, p1, p2;
    in_flag = 1'b1;
    in_data = base + 8'(16 * r + c);
    clr     = 1'b0;
    @(posedge sclk); #1;
    in_flag = 1'b0;
    if (r >= LINES - 1) begin
      p0 = base + 8'(16 * r + c);
      p1 = base + 8'(16 * (r - 1) + c);
      p2 = base + 8'(16 * (r - 2) + c);
      check("out_flag", 32'(out_flag), 32'd1);
      check("out_col",  32'(out_col), {8'h00, p2, p1, p0});
      check("out_x",    32'(out_x), 32'(c));
      check("out_y",    32'(out_y), 32'(r));
      check("frame_end", 32'(frame_end), 32'((r == IMG_H - 1) && (c == IMG_W - 1)));
      pulses++;
      held_valid = 1'b1;
      held_col   = {p2, p1, p0};
      held_x     = 2'(c);
      held_y     = 2'(r);
    end else begin
      check("prime_flag", 32'(out_flag), 32'd0);
      check("prime_fend", 32'(frame_end), 32'd0);
      held_valid = 1'b0;
    end
  endtask

  // Full frame with optional random idle gaps; hand constants for first/last column.
  task automatic run_frame(input logic [7:0] base, input int max_gap,
                           input logic [23:0] first_exp, input logic [23:0] last_exp);
    pulses = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        pixel(base, r, c);
        if (r == 2 && c == 0) check("first_col", 32'(out_col), 32'(first_exp));
        if (r == 3 && c == 3) check("last_col",  32'(out_col), 32'(last_exp));
      end
    end
    check("pulse_count", 32'(pulses), 32'd8);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_flag = 1'b0;
    in_data = '0;
    clr     = 1'b0;

    // Reset state.
    @(posedge sclk); @(posedge sclk); #1;
    check("rst_flag", 32'(out_flag), 32'd0);
    check("rst_fend", 32'(frame_end), 32'd0);
    check("rst_col",  32'(out_col), 32'd0);
    check("rst_x",    32'(out_x), 32'd0);
    check("rst_y",    32'(out_y), 32'd0);
    rst_n = 1'b1;

    // Continuous frame, then back-to-back frame with values +0x80.
    run_frame(8'h00, 0, 24'h001020, 24'h132333);
    run_frame(8'h80, 0, 24'h8090A0, 24'h93A3B3);
    idle(2);

    // Same frame with 0..5 idle cycles between pixels.
    run_frame(8'h00, 5, 24'h001020, 24'h132333);
    idle(1);

    // clr together with pixel 0x21 drops it and restarts the frame.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < IMG_W; c++) pixel(8'h00, r, c);
    pixel(8'h00, 2, 0);
    in_flag = 1'b1; in_data = 8'h21; clr = 1'b1;
    @(posedge sclk); #1;
    in_flag = 1'b0; clr = 1'b0;
    held_valid = 1'b0;
    check("clr_flag", 32'(out_flag), 32'd0);
    check("clr_fend", 32'(frame_end), 32'd0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < IMG_W; c++) pixel(8'h40, r, c);
    pixel(8'h40, 2, 0);
    check("clr_first_col", 32'(out_col), 32'h00405060);
    for (int c = 1; c < IMG_W; c++) pixel(8'h40, 2, c);
    pixel(8'h40, 3, 0);
    pixel(8'h40, 3, 1);

    // Mid-frame reset with a pixel presented: reset wins, outputs cleared.
    rst_n = 1'b0; in_flag = 1'b1; in_data = 8'h99;
    for (int i = 0; i < 2; i++) begin
      @(posedge sclk); #1;
      check("mrst_flag", 32'(out_flag), 32'd0);
      check("mrst_fend", 32'(frame_end), 32'd0);
      check("mrst_col",  32'(out_col), 32'd0);
      check("mrst_x",    32'(out_x), 32'd0);
      check("mrst_y",    32'(out_y), 32'd0);
    end
    rst_n = 1'b1; in_flag = 1'b0;
    held_valid = 1'b0;
    run_frame(8'h00, 0, 24'h001020, 24'h132333);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
